branch_target_buffer: RTL and testbench

Fetch-stage branch target buffer and next-PC selector. It is direct-mapped and paired with the tournament direction predictor. In the fetch stage, the BTB supplies the predicted target for `regF_pc_i`, and the predictor's `predict_taken` selects between that target and the fall-through address. In the execute stage, the block compares the resolved branch against the prediction carried down the pipe, raises a redirect on mismatch, and allocates or refreshes the BTB entry.

---
 rtl/branch_target_buffer.sv | 126 ++++++++++++
 tb/tb_branch_target_buffer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// Direct-mapped branch target buffer with next-PC selection and misprediction redirect.
// Taken branches resolved in execute are staged through a one-entry write buffer before reaching the table.
module branch_target_buffer #(
  parameter int BTB_ENTRIES = 64,
  parameter int TAG_BITS    = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] regF_pc_i,
  input  logic        predict_taken,
  input  logic [31:0] execute_pc_i,
  input  logic        execute_branch,
  input  logic        branch_taken,
  input  logic [31:0] execute_target_i,
  input  logic        exe_pred_taken_i,
  input  logic [31:0] exe_pred_target_i,
  output logic        btb_hit_o,
  output logic [31:0] btb_target_o,
  output logic [31:0] next_pc_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] hit_cnt_o,
  output logic [31:0] mispred_cnt_o
);

  localparam int IDX = $clog2(BTB_ENTRIES);

  logic [BTB_ENTRIES-1:0] valid_reg;
  logic [TAG_BITS-1:0]    tag_mem    [BTB_ENTRIES];
  logic [31:0]            target_mem [BTB_ENTRIES];

  logic                wb_valid_reg;
  logic [IDX-1:0]      wb_idx_reg;
  logic [TAG_BITS-1:0] wb_tag_reg;
  logic [31:0]         wb_target_reg;

  logic [31:0] hit_cnt_reg, hit_cnt_next;
  logic [31:0] mispred_cnt_reg, mispred_cnt_next;

  logic [IDX-1:0]      fetch_idx, exe_idx;
  logic [TAG_BITS-1:0] fetch_tag, exe_tag;
  logic                bypass, entry_valid, hit, alloc, mispredict;
  logic [TAG_BITS-1:0] entry_tag;
  logic [31:0]         entry_target, pred_pc, redirect_pc;

  assign fetch_idx = regF_pc_i[IDX+1:2];
  assign fetch_tag = regF_pc_i[IDX+TAG_BITS+1:IDX+2];
  assign exe_idx   = execute_pc_i[IDX+1:2];
  assign exe_tag   = execute_pc_i[IDX+TAG_BITS+1:IDX+2];

  // Byte-offset bits and any bits above the tag take no part in lookup.
  logic unused_pc_bits;
  generate
    if (IDX + TAG_BITS + 2 < 32) begin : g_upper_bits
      assign unused_pc_bits = ^{regF_pc_i[1:0], execute_pc_i[1:0],
                                regF_pc_i[31:IDX+TAG_BITS+2], execute_pc_i[31:IDX+TAG_BITS+2]};
    end else begin : g_no_upper_bits
      assign unused_pc_bits = ^{regF_pc_i[1:0], execute_pc_i[1:0]};
    end
  endgenerate

  // A pending write-buffer entry shadows the table slot it is about to overwrite.
  always_comb begin
    bypass       = wb_valid_reg && (wb_idx_reg == fetch_idx);
    entry_valid  = bypass ? 1'b1 : valid_reg[fetch_idx];
    entry_tag    = bypass ? wb_tag_reg : tag_mem[fetch_idx];
    entry_target = bypass ? wb_target_reg : target_mem[fetch_idx];
    hit          = rst && entry_valid && (entry_tag == fetch_tag);
  end

  assign btb_hit_o    = hit;
  assign btb_target_o = hit ? entry_target : 32'd0;
  assign pred_pc      = (hit && predict_taken) ? entry_target : regF_pc_i + 32'd4;

  // Redirect depends only on execute-stage inputs, never on the fetch PC.
  assign mispredict  = execute_branch &&
                       ((branch_taken != exe_pred_taken_i) ||
                        (branch_taken && (exe_pred_target_i != execute_target_i)));
  assign redirect_pc = branch_taken ? execute_target_i : execute_pc_i + 32'd4;

  assign redirect_o    = mispredict;
  assign redirect_pc_o = redirect_pc;
  assign next_pc_o     = mispredict ? redirect_pc : pred_pc;

  assign alloc = execute_branch && branch_taken;

  assign hit_cnt_next     = (hit && hit_cnt_reg != 32'hFFFF_FFFF) ? hit_cnt_reg + 32'd1 : hit_cnt_reg;
  assign mispred_cnt_next = (mispredict && mispred_cnt_reg != 32'hFFFF_FFFF) ?
                            mispred_cnt_reg + 32'd1 : mispred_cnt_reg;

  // Tag/target storage carries no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (wb_valid_reg) begin
      tag_mem[wb_idx_reg]    <= wb_tag_reg;
      target_mem[wb_idx_reg] <= wb_target_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_reg       <= '0;
      wb_valid_reg    <= 1'b0;
      wb_idx_reg      <= '0;
      wb_tag_reg      <= '0;
      wb_target_reg   <= '0;
      hit_cnt_reg     <= '0;
      mispred_cnt_reg <= '0;
    end else begin
      if (wb_valid_reg) begin
        valid_reg[wb_idx_reg] <= 1'b1;
      end
      wb_valid_reg <= alloc;
      if (alloc) begin
        wb_idx_reg    <= exe_idx;
        wb_tag_reg    <= exe_tag;
        wb_target_reg <= execute_target_i;
      end
      hit_cnt_reg     <= hit_cnt_next;
      mispred_cnt_reg <= mispred_cnt_next;
    end
  end

  assign hit_cnt_o     = hit_cnt_reg;
  assign mispred_cnt_o = mispred_cnt_reg;

endmodule

// File: tb/tb_branch_target_buffer.sv
// Self-checking bench for branch_target_buffer: directed scenarios plus a randomized run
// compared against an architectural model (table updated at the allocating edge).
module tb_branch_target_buffer;

  localparam int N  = 64;
  localparam int TB = 24;
  localparam logic [31:0] LINE    = 32'(4 * N);
  localparam logic [31:0] TAG_MOD = 32'd1 << TB;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] regF_pc_i = '0;
  logic        predict_taken = 1'b0;
  logic [31:0] execute_pc_i = '0;
  logic        execute_branch = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] execute_target_i = '0;
  logic        exe_pred_taken_i = 1'b0;
  logic [31:0] exe_pred_target_i = '0;
  logic        btb_hit_o;
  logic [31:0] btb_target_o, next_pc_o, redirect_pc_o, hit_cnt_o, mispred_cnt_o;
  logic        redirect_o;

  branch_target_buffer #(.BTB_ENTRIES(N), .TAG_BITS(TB)) dut (
    .clk(clk), .rst(rst),
    .regF_pc_i(regF_pc_i), .predict_taken(predict_taken),
    .execute_pc_i(execute_pc_i), .execute_branch(execute_branch),
    .branch_taken(branch_taken), .execute_target_i(execute_target_i),
    .exe_pred_taken_i(exe_pred_taken_i), .exe_pred_target_i(exe_pred_target_i),
    .btb_hit_o(btb_hit_o), .btb_target_o(btb_target_o), .next_pc_o(next_pc_o),
    .redirect_o(redirect_o), .redirect_pc_o(redirect_pc_o),
    .hit_cnt_o(hit_cnt_o), .mispred_cnt_o(mispred_cnt_o)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Architectural view of the buffer: what a lookup sees after each edge.
  bit          model_valid [N];
  logic [31:0] model_tag   [N];
  logic [31:0] model_tgt   [N];
  logic [31:0] model_hits = '0;
  logic [31:0] model_misp = '0;

  function automatic int unsigned idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'(N));
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return (pc / LINE) % TAG_MOD;
  endfunction

  function automatic logic exp_hit();
    int unsigned i = idx_of(regF_pc_i);
    return rst && model_valid[i] && (model_tag[i] == tag_of(regF_pc_i));
  endfunction

  function automatic logic [31:0] exp_target();
    return exp_hit() ? model_tgt[idx_of(regF_pc_i)] : 32'd0;
  endfunction

  function automatic logic exp_misp();
    return execute_branch && ((branch_taken != exe_pred_taken_i) ||
                              (branch_taken && exe_pred_target_i != execute_target_i));
  endfunction

  function automatic logic [31:0] exp_rpc();
    return branch_taken ? execute_target_i : execute_pc_i + 32'd4;
  endfunction

  function automatic logic [31:0] exp_next();
    if (exp_misp()) return exp_rpc();
    return (exp_hit() && predict_taken) ? exp_target() : regF_pc_i + 32'd4;
  endfunction

  // Advance one cycle from a falling edge to the next, updating the model at the rising edge.
  task automatic tick();
    logic h, m;
    h = exp_hit();
    m = exp_misp();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < N; i++) model_valid[i] = 1'b0;
      model_hits = '0;
      model_misp = '0;
    end else begin
      if (h && model_hits != 32'hFFFF_FFFF) model_hits = model_hits + 32'd1;
      if (m && model_misp != 32'hFFFF_FFFF) model_misp = model_misp + 32'd1;
      if (execute_branch && branch_taken) begin
        model_valid[idx_of(execute_pc_i)] = 1'b1;
        model_tag[idx_of(execute_pc_i)]   = tag_of(execute_pc_i);
        model_tgt[idx_of(execute_pc_i)]   = execute_target_i;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_exec(input logic eb, input logic bt, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
    execute_branch = eb; branch_taken = bt; execute_pc_i = pc;
    execute_target_i = tgt; exe_pred_taken_i = pt; exe_pred_target_i = ptgt;
  endtask

  task automatic test_reset();
    rst = 1'b0; regF_pc_i = 32'h100; predict_taken = 1'b1;
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    #1;
    vectors++; if (btb_hit_o !== 1'b0) begin miscompares++; $display("FAIL reset_hit_during got=%b exp=0", btb_hit_o); end
    vectors++; if (next_pc_o !== 32'h104) begin miscompares++; $display("FAIL reset_next_during got=%h exp=00000104", next_pc_o); end
    tick(); tick();
    rst = 1'b1;
    #1;
    vectors++; if (btb_hit_o !== 1'b0) begin miscompares++; $display("FAIL reset_hit got=%b exp=0", btb_hit_o); end
    vectors++; if (btb_target_o !== 32'h0) begin miscompares++; $display("FAIL reset_target got=%h exp=0", btb_target_o); end
    vectors++; if (next_pc_o !== 32'h104) begin miscompares++; $display("FAIL reset_next got=%h exp=00000104", next_pc_o); end
    vectors++; if (hit_cnt_o !== 32'h0) begin miscompares++; $display("FAIL reset_hit_cnt got=%h exp=0", hit_cnt_o); end
    vectors++; if (mispred_cnt_o !== 32'h0) begin miscompares++; $display("FAIL reset_mispred_cnt got=%h exp=0", mispred_cnt_o); end
    tick();
  endtask

  task automatic test_alloc_hit();
    set_exec(1'b1, 1'b1, 32'h200, 32'h400, 1'b1, 32'h400);
    regF_pc_i = 32'h100; predict_taken = 1'b1;
    #1;
    vectors++; if (redirect_o !== 1'b0) begin miscompares++; $display("FAIL alloc_no_redirect got=%b exp=0", redirect_o); end
    tick();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    regF_pc_i = 32'h200;
    #1;
    vectors++; if (btb_hit_o !== 1'b1) begin miscompares++; $display("FAIL bypass_hit got=%b exp=1", btb_hit_o); end
    vectors++; if (btb_target_o !== 32'h400) begin miscompares++; $display("FAIL bypass_target got=%h exp=00000400", btb_target_o); end
    vectors++; if (next_pc_o !== 32'h400) begin miscompares++; $display("FAIL bypass_next got=%h exp=00000400", next_pc_o); end
    tick();
    vectors++; if (hit_cnt_o !== model_hits) begin miscompares++; $display("FAIL hit_cnt_inc got=%h exp=%h", hit_cnt_o, model_hits); end
  endtask

  task automatic test_alias();
    logic [31:0] wrap_pc;
    wrap_pc = 32'h200 + (LINE << TB);
    regF_pc_i = wrap_pc; predict_taken = 1'b1;
    #1;
    vectors++; if (btb_hit_o !== 1'b1) begin miscompares++; $display("FAIL alias_wrap_hit got=%b exp=1", btb_hit_o); end
    tick();
    regF_pc_i = 32'h200 + LINE;
    #1;
    vectors++; if (btb_hit_o !== 1'b0) begin miscompares++; $display("FAIL alias_miss_hit got=%b exp=0", btb_hit_o); end
    vectors++; if (next_pc_o !== 32'h200 + LINE + 32'd4) begin miscompares++; $display("FAIL alias_miss_next got=%h exp=%h", next_pc_o, 32'h204 + LINE); end
    tick();
  endtask

  task automatic test_dir_mispredict();
    set_exec(1'b1, 1'b0, 32'h300, 32'h700, 1'b1, 32'h700);
    regF_pc_i = 32'h1000; predict_taken = 1'b0;
    #1;
    vectors++; if (redirect_o !== 1'b1) begin miscompares++; $display("FAIL dir_redirect got=%b exp=1", redirect_o); end
    vectors++; if (redirect_pc_o !== 32'h304) begin miscompares++; $display("FAIL dir_redirect_pc got=%h exp=00000304", redirect_pc_o); end
    vectors++; if (next_pc_o !== 32'h304) begin miscompares++; $display("FAIL dir_next got=%h exp=00000304", next_pc_o); end
    tick();
    vectors++; if (mispred_cnt_o !== model_misp) begin miscompares++; $display("FAIL dir_mispred_cnt got=%h exp=%h", mispred_cnt_o, model_misp); end
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    regF_pc_i = 32'h300; predict_taken = 1'b1;
    #1;
    vectors++; if (btb_hit_o !== 1'b0) begin miscompares++; $display("FAIL dir_no_alloc got=%b exp=0", btb_hit_o); end
    tick(); tick();
    #1;
    vectors++; if (btb_hit_o !== 1'b0) begin miscompares++; $display("FAIL dir_no_alloc_late got=%b exp=0", btb_hit_o); end
  endtask

  task automatic test_target_mispredict();
    set_exec(1'b1, 1'b1, 32'h200, 32'h600, 1'b1, 32'h500);
    regF_pc_i = 32'h2000; predict_taken = 1'b0;
    #1;
    vectors++; if (redirect_o !== 1'b1) begin miscompares++; $display("FAIL tgt_redirect got=%b exp=1", redirect_o); end
    vectors++; if (redirect_pc_o !== 32'h600) begin miscompares++; $display("FAIL tgt_redirect_pc got=%h exp=00000600", redirect_pc_o); end
    vectors++; if (next_pc_o !== 32'h600) begin miscompares++; $display("FAIL tgt_next got=%h exp=00000600", next_pc_o); end
    tick();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    regF_pc_i = 32'h200; predict_taken = 1'b1;
    #1;
    vectors++; if (btb_target_o !== 32'h600) begin miscompares++; $display("FAIL tgt_refresh got=%h exp=00000600", btb_target_o); end
    vectors++; if (mispred_cnt_o !== model_misp) begin miscompares++; $display("FAIL tgt_mispred_cnt got=%h exp=%h", mispred_cnt_o, model_misp); end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [31:0] pcs  [3];
    logic [31:0] tgts [3];
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'h4;
    tgts[0] = 32'h1110; tgts[1] = 32'h2220; tgts[2] = 32'h3330;
    regF_pc_i = 32'h4; predict_taken = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_exec(1'b1, 1'b1, pcs[k], tgts[k], 1'b1, tgts[k]);
      #1;
      vectors++; if (btb_target_o !== exp_target()) begin miscompares++; $display("FAIL b2b_lookup_%0d got=%h exp=%h", k, btb_target_o, exp_target()); end
      tick();
    end
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    #1;
    vectors++; if (btb_target_o !== 32'h3330) begin miscompares++; $display("FAIL b2b_idx1_bypass got=%h exp=00003330", btb_target_o); end
    tick(); tick();
    #1;
    vectors++; if (btb_target_o !== 32'h3330) begin miscompares++; $display("FAIL b2b_idx1_table got=%h exp=00003330", btb_target_o); end
    regF_pc_i = 32'h8;
    #1;
    vectors++; if (btb_target_o !== 32'h2220) begin miscompares++; $display("FAIL b2b_idx2_table got=%h exp=00002220", btb_target_o); end
    tick();
  endtask

  task automatic test_saturation();
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    force dut.mispred_cnt_reg = 32'hFFFF_FFFE;
    #1;
    release dut.mispred_cnt_reg;
    model_misp = 32'hFFFF_FFFE;
    #1;
    vectors++; if (mispred_cnt_o !== 32'hFFFF_FFFE) begin miscompares++; $display("FAIL sat_preload got=%h exp=fffffffe", mispred_cnt_o); end
    for (int k = 0; k < 3; k++) begin
      set_exec(1'b1, 1'b0, 32'h40 + 32'(k * 4), 32'h0, 1'b1, 32'h0);
      tick();
      vectors++; if (mispred_cnt_o !== model_misp) begin miscompares++; $display("FAIL sat_step_%0d got=%h exp=%h", k, mispred_cnt_o, model_misp); end
    end
    vectors++; if (mispred_cnt_o !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL sat_final got=%h exp=ffffffff", mispred_cnt_o); end
    set_exec(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    tick();
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 49) != 0);
      regF_pc_i = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
      predict_taken = 1'($urandom_range(0, 1));
      tgt = 32'($urandom) & 32'hFFFF_FFFC;
      set_exec(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2),
               tgt, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 3) != 0) ? tgt : tgt + 32'h10);
      #1;
      vectors++; if (btb_hit_o !== exp_hit()) begin miscompares++; $display("FAIL rnd_hit c=%0d got=%b exp=%b", c, btb_hit_o, exp_hit()); end
      vectors++; if (btb_target_o !== exp_target()) begin miscompares++; $display("FAIL rnd_target c=%0d got=%h exp=%h", c, btb_target_o, exp_target()); end
      vectors++; if (redirect_o !== exp_misp()) begin miscompares++; $display("FAIL rnd_redirect c=%0d got=%b exp=%b", c, redirect_o, exp_misp()); end
      if (exp_misp()) begin
        vectors++; if (redirect_pc_o !== exp_rpc()) begin miscompares++; $display("FAIL rnd_redirect_pc c=%0d got=%h exp=%h", c, redirect_pc_o, exp_rpc()); end
      end
      vectors++; if (next_pc_o !== exp_next()) begin miscompares++; $display("FAIL rnd_next c=%0d got=%h exp=%h", c, next_pc_o, exp_next()); end
      tick();
      vectors++; if (hit_cnt_o !== model_hits) begin miscompares++; $display("FAIL rnd_hit_cnt c=%0d got=%h exp=%h", c, hit_cnt_o, model_hits); end
      vectors++; if (mispred_cnt_o !== model_misp) begin miscompares++; $display("FAIL rnd_mispred_cnt c=%0d got=%h exp=%h", c, mispred_cnt_o, model_misp); end
    end
    rst = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      model_valid[i] = 1'b0;
      model_tag[i]   = '0;
      model_tgt[i]   = '0;
    end
    test_reset();
    test_alloc_hit();
    test_alias();
    test_dir_mispredict();
    test_target_mispredict();
    test_back_to_back();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
